hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It replaces the fixed five-stage hazard logic with a shift-register scoreboard of in-flight destination registers. The scoreboard supports any number of post-decode stages, per-instruction result-ready stage (ALU, load, longer ops) and a downstream hold for multi-cycle execute units. It sits beside the register file in decode and drives PC/IF_ID stall, IF_ID/ID_EX flush and the decode and execute forwarding muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard_haz_lookup.sv | 37 +++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-code encoding and the
// layout of one scoreboard entry, packed as {rdy, wreg, v}.
package hazard_defs;

    localparam int FWD_RF       = 0;
    localparam int ENT_V        = 0;
    localparam int ENT_WREG_LSB = 1;

    function automatic int ent_rdy_lsb(int aw);
        return 1 + aw;
    endfunction

    function automatic int ent_width(int aw, int rw);
        return 1 + aw + rw;
    endfunction

    // Datapath mux code that selects the pipeline register after stage j.
    function automatic int fwd_after_stage(int j);
        return j + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline control and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int NSTAGE = 3,
    parameter int REG_AW = 5,
    parameter int RW     = $clog2(NSTAGE)
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic              d_branch;
    logic              d_wr;
    logic [REG_AW-1:0] d_wreg;
    logic [RW-1:0]     d_rdy;
    logic              hold;
    logic              pcsrc;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [RW-1:0]     fwd_ad;
    logic [RW-1:0]     fwd_bd;
    logic [RW-1:0]     fwd_ae;
    logic [RW-1:0]     fwd_be;
    logic [NSTAGE-1:0] pend;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_branch,
               d_wr, d_wreg, d_rdy, hold, pcsrc,
        input  stall_f, stall_d, flush_d, flush_e,
               fwd_ad, fwd_bd, fwd_ae, fwd_be, pend
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_branch,
               d_wr, d_wreg, d_rdy, hold, pcsrc,
        output stall_f, stall_d, flush_d, flush_e,
               fwd_ad, fwd_bd, fwd_ae, fwd_be, pend
    );
endinterface

// File: rtl/hazard_scoreboard_haz_lookup.sv
// Finds the youngest in-flight writer of one source register and reports
// its stage index and result-ready stage.
module haz_lookup
    import hazard_defs::*;
#(
    parameter int NSTAGE = 3,
    parameter int REG_AW = 5,
    parameter int RW     = $clog2(NSTAGE)
) (
    input  logic [REG_AW-1:0]                  src,
    input  logic                               use_src,
    input  logic [NSTAGE-1:0][REG_AW+RW:0]     entries,
    output logic                               hit,
    output logic [RW-1:0]                      k,
    output logic [RW-1:0]                      rdy
);

    localparam int RDY_LSB = ent_rdy_lsb(REG_AW);

    // Scan oldest to youngest so the smallest matching index wins.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        rdy = '0;
        if (use_src && (src != '0)) begin
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (entries[i][ENT_V] &&
                    (entries[i][REG_AW:ENT_WREG_LSB] == src)) begin
                    hit = 1'b1;
                    k   = RW'(i);
                    rdy = entries[i][RDY_LSB+RW-1:RDY_LSB];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based stall/flush/forward controller for the in-order pipeline.
// Define HAZ_BRANCH_FWD_EN to enable forwarding into the decode branch comparator.
module hazard_scoreboard
    import hazard_defs::*;
#(
    parameter int NSTAGE = 3,
    parameter int REG_AW = 5,
    parameter int RW     = $clog2(NSTAGE)
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hif
);

    localparam int            EW      = ent_width(REG_AW, RW);
    localparam logic [RW-1:0] LAST    = RW'(NSTAGE - 1);
    localparam logic [RW-1:0] RDY_MAX = RW'(NSTAGE - 2);
    localparam logic [RW-1:0] CODE_RF = RW'(FWD_RF);

    logic [NSTAGE-1:0][EW-1:0] ent;
    logic [EW-1:0]             new_ent;
    logic [RW-1:0]             rdy_in;
    logic                      v_new;
    logic                      hit_a, hit_b;
    logic [RW-1:0]             k_a, k_b, rdy_a, rdy_b;
    logic                      haz_a, haz_b, hazard;
    logic [RW-1:0]             fwd_ae_q, fwd_be_q;
    logic [NSTAGE-1:0]         pend;

    haz_lookup #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .RW(RW)) u_lookup_rs (
        .src     (hif.d_rs),
        .use_src (hif.d_use_rs),
        .entries (ent),
        .hit     (hit_a),
        .k       (k_a),
        .rdy     (rdy_a)
    );

    haz_lookup #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .RW(RW)) u_lookup_rt (
        .src     (hif.d_rt),
        .use_src (hif.d_use_rt),
        .entries (ent),
        .hit     (hit_b),
        .k       (k_b),
        .rdy     (rdy_b)
    );

    // The writeback stage is covered by the write-first register file.
    function automatic logic [RW-1:0] exec_code(logic hit, logic [RW-1:0] k);
        if (!hit || (k == LAST))
            return CODE_RF;
        return RW'(fwd_after_stage(int'(k)));
    endfunction

    function automatic logic exec_haz(logic hit, logic [RW-1:0] k, logic [RW-1:0] rdy);
        return hit && (k < rdy);
    endfunction

`ifdef HAZ_BRANCH_FWD_EN
    // The comparator sits one stage earlier than E, so it needs one more stage of slack.
    function automatic logic br_haz(logic hit, logic [RW-1:0] k, logic [RW-1:0] rdy);
        return hit && (int'(k) < int'(rdy) + 1);
    endfunction

    function automatic logic [RW-1:0] br_code(logic hit, logic [RW-1:0] k);
        if (!hit || (k == LAST))
            return CODE_RF;
        return k;
    endfunction

    assign hif.fwd_ad = br_code(hit_a, k_a);
    assign hif.fwd_bd = br_code(hit_b, k_b);
`else
    function automatic logic br_haz(logic hit, logic [RW-1:0] k, logic [RW-1:0] rdy);
        return hit && (k < LAST) && (rdy <= LAST);
    endfunction

    assign hif.fwd_ad = CODE_RF;
    assign hif.fwd_bd = CODE_RF;
`endif

    always_comb begin
        haz_a  = hif.d_branch ? br_haz(hit_a, k_a, rdy_a) : exec_haz(hit_a, k_a, rdy_a);
        haz_b  = hif.d_branch ? br_haz(hit_b, k_b, rdy_b) : exec_haz(hit_b, k_b, rdy_b);
        hazard = hif.d_valid && (haz_a || haz_b);
    end

    assign hif.stall_f = hazard | hif.hold;
    assign hif.stall_d = hazard | hif.hold;
    assign hif.flush_e = hazard & ~hif.hold;
    assign hif.flush_d = hif.pcsrc & ~(hazard | hif.hold);

    // Out-of-range ready stages are clamped to the last forwardable stage.
    always_comb begin
        rdy_in  = (hif.d_rdy > RDY_MAX) ? RDY_MAX : hif.d_rdy;
        v_new   = hif.d_valid & ~hazard & hif.d_wr & (hif.d_wreg != '0);
        new_ent = {rdy_in, hif.d_wreg, v_new};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent      <= '0;
            fwd_ae_q <= '0;
            fwd_be_q <= '0;
        end else if (!hif.hold) begin
            ent      <= {ent[NSTAGE-2:0], new_ent};
            fwd_ae_q <= hazard ? CODE_RF : exec_code(hit_a, k_a);
            fwd_be_q <= hazard ? CODE_RF : exec_code(hit_b, k_b);
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NSTAGE; i++)
            pend[i] = ent[i][ENT_V];
    end

    assign hif.fwd_ae = fwd_ae_q;
    assign hif.fwd_be = fwd_be_q;
    assign hif.pend   = pend;

endmodule
